// File: rtl/counter_cfg_pkg.sv
// Shared types and next-count helper for the configurable up/down counter.
package counter_cfg_pkg;

    // Widest counter the helper supports; callers zero-extend and truncate.
    localparam int unsigned CNT_MAX_W = 64;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    typedef struct packed {
        logic                 wrap;
        logic [CNT_MAX_W-1:0] value;
    } next_cnt_t;

    // One step of the counter; terminal detection is by comparison only.
    function automatic next_cnt_t next_count(
        input logic [CNT_MAX_W-1:0] count,
        input logic [CNT_MAX_W-1:0] max,
        input logic                 up,
        input cnt_mode_e            mode
    );
        next_cnt_t r;
        r.value = count;
        r.wrap  = 1'b0;
        if (up) begin
            if (count < max) begin
                r.value = count + CNT_MAX_W'(1);
            end else if (mode == CNT_WRAP) begin
                r.value = '0;
                r.wrap  = 1'b1;
            end else begin
                r.value = max;
            end
        end else begin
            if (count != '0) begin
                r.value = count - CNT_MAX_W'(1);
            end else if (mode == CNT_WRAP) begin
                r.value = max;
                r.wrap  = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles into count ticks: one tick every PRESCALE enabled cycles.
module counter_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    generate
        if (PRESCALE <= 1) begin : g_direct
            // Every enabled cycle is a tick; no phase state to keep.
            logic unused_presc;
            assign unused_presc = &{1'b0, clk, rst_n, clr_i};
            assign tick_o       = en_i;
        end else begin : g_div
            localparam int unsigned PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] cnt;

            // Phase counter: cleared by reset or load, advances only while enabled.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clr_i) begin
                    cnt <= '0;
                end else if (en_i) begin
                    cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
                end
            end

            assign tick_o = en_i && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/counter_cfg.sv
// Parametrised up/down counter with load, wrap/saturate mode and registered flags.
module counter_cfg
    import counter_cfg_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] max_val_i,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    output logic             underflow,
    output logic             wrap_o
);

    logic             tick;
    logic             dir_q;
    logic [WIDTH-1:0] count_d;
    logic             dir_d;
    logic             wrap_d;
    logic             ovf_d;
    logic             udf_d;
    next_cnt_t        nc;
    logic             unused_nc;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en_i),
        .clr_i  (load_i),
        .tick_o (tick)
    );

    // Candidate step uses the current up_i so a direction change applies immediately.
    assign nc        = next_count(CNT_MAX_W'(count), CNT_MAX_W'(max_val_i),
                                  up_i, cnt_mode_e'(mode_i));
    assign unused_nc = ^nc;

    // Next-state: load beats step beats hold; flags follow the next count/direction.
    always_comb begin
        count_d = count;
        dir_d   = up_i;
        wrap_d  = 1'b0;
        if (load_i) begin
            count_d = (load_val_i > max_val_i) ? max_val_i : load_val_i;
        end else if (tick) begin
            count_d = WIDTH'(nc.value);
            wrap_d  = nc.wrap;
        end
        ovf_d = (count_d == max_val_i) & dir_d;
        udf_d = (count_d == '0) & ~dir_d;
    end

    // State and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            dir_q     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            wrap_o    <= 1'b0;
        end else begin
            count     <= count_d;
            dir_q     <= dir_d;
            overflow  <= ovf_d;
            underflow <= udf_d;
            wrap_o    <= wrap_d;
        end
    end

endmodule

// File: doc/counter_cfg.md
# counter_cfg

Parametrised up/down counter that generalises the team's fixed 8-bit free-running counter. Width, prescale and terminal value are configurable, and it supports direction, synchronous load, and a wrap or saturate mode. Overflow and underflow flags are registered, plus a one-cycle wrap pulse. It sits in the timer/event-counting path. With WIDTH=8, PRESCALE=1, max_val=8'hFF, up, en=1 and wrap mode, it behaves cycle-for-cycle like the legacy 8-bit counter.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- PRESCALE, 1, enabled cycles per count step (≥1)
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- en_i  input  1  count enable; prescaler advances only when high
- up_i  input  1  direction: 1 = up, 0 = down
- mode_i  input  1  0 = wrap, 1 = saturate (cnt_mode_e)
- load_i  input  1  synchronous load strobe
- load_val_i  input  WIDTH  value to load
- max_val_i  input  WIDTH  terminal (maximum) count value
- count  output  WIDTH  current count
- overflow  output  1  count == max_val and registered direction up
- underflow  output  1  count == 0 and registered direction down
- wrap_o  output  1  one-cycle pulse following a wrap step

## Operation
- Reset (rst_n=0 at a rising edge): count=0, dir_q=up, prescaler=0, overflow=0, underflow=0, wrap_o=0.
- Priority per cycle: reset > load > step > hold.
- Load: count ← min(load_val_i, max_val_i); prescaler ← 0; dir_q ← up_i; wrap_o=0.
- Tick: asserted when en_i=1 and prescaler == PRESCALE-1.
  - The prescaler then returns to 0; otherwise it increments while en_i=1.
  - It holds while en_i=0.
  - PRESCALE=1 means a tick on every enabled cycle.
- Step on tick, up:
  - count < max_val: count+1.
  - count ≥ max_val, wrap mode: count ← 0 and wrap_o pulses.
  - count ≥ max_val, saturate mode: count ← max_val, no wrap_o.
- Step on tick, down:
  - count > 0: count-1.
  - count = 0, wrap mode: count ← max_val and wrap_o pulses.
  - count = 0, saturate mode: count stays 0.
- dir_q ← up_i on every non-reset cycle.
- Flags are registered and computed from the next count and next dir_q, so they align with count:
  - overflow = (count==max_val)&dir_q.
  - underflow = (count==0)&~dir_q.
- Runtime max_val_i lowered below count: the next up step goes through the wrap/saturate path above. Down steps decrement normally.
- max_val_i=0: count stays 0; every tick in wrap mode pulses wrap_o.
- Arithmetic is WIDTH-bit unsigned. There is no carry out; terminal detection is by comparison, never by natural rollover.

## Timing
- Step latency: count updates on the rising edge where the tick is true and is visible after that edge.
- Load latency: 1 cycle.
- Flags latency: 0 cycles relative to count (same edge).
- wrap_o is high for exactly the one cycle after the wrapping edge. Back-to-back wraps (e.g. max_val=0) give a continuous high.
- Reset is sampled only at clock edges. Asserting it mid-count clears all state on that edge, and the prescaler phase is lost.
- load_i and a tick in the same cycle: load wins and the tick is discarded.
- Changing up_i and ticking in the same cycle: the new direction is used for that step.

## Structure
- Package counter_cfg_pkg contains:
  - typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e.
  - A helper function next_count(count, max, up, mode) that returns the next value and a wrap bit.
- Sub-module counter_prescaler (parameter PRESCALE; ports clk, rst_n, en_i, clr_i, tick_o) holds the prescaler.
  - $clog2(PRESCALE)-bit register.
  - Tied to constant en_i for PRESCALE=1.
- The top level instantiates the prescaler and holds the count, dir_q and flag registers.

## Test plan
- Legacy compatibility (WIDTH=8, PRESCALE=1, max=FF, up, wrap):
  - Hold reset 4 cycles → count=00.
  - Release, then 255 edges → count=FF, overflow=1.
  - +1 edge → count=00, overflow=0, wrap_o=1.
  - +10 edges → count=0A.
- Down wrap (max=09, up=0, wrap):
  - Load 02, then 3 ticks → count 01, 00 (underflow=1), 09 (wrap_o=1).
- Saturate (max=0F, mode=1):
  - Load 0E, then 5 up ticks → count 0F held, overflow=1, wrap_o never 1.
  - Up=0, 16 ticks → 00 held, underflow=1.
- Prescale (PRESCALE=4):
  - en=1 for 12 cycles → count 3, with steps on cycles 4, 8 and 12.
  - Drop en for 2 cycles in the middle → those cycles are not counted.
- Load conflicts:
  - load_i with tick, load_val=05 → count 05.
  - load_val=30 with max=20 → count 20.
  - Lower max to 03 while count=10, then an up tick → count 00 (wrap) or 03 (saturate).
- Reset mid-operation:
  - rst_n=0 for one edge while count=7F → next cycle count=00, all flags 0, prescaler restarts at 0.
